dl_rr_arb8: RTL
===============

DL_RR_ARB8 -- requirements
Module: dl_rr_arb8

Interface
REQ-001 Parameter NUM_BITS SHALL default to 32; it sets the width of each message.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_val  input  8  SHALL carry per-requester valid; bit i is requester i.
REQ-005 req_msg  input  8*NUM_BITS  SHALL carry packed messages; requester i at bits [i*NUM_BITS +: NUM_BITS].
REQ-006 req_rdy  output  8  SHALL carry per-requester accept; at most one bit high per cycle.
REQ-007 out_val  output  1  SHALL indicate that the output register holds a valid message.
REQ-008 out_msg  output  NUM_BITS  SHALL carry the registered granted message.
REQ-009 out_src  output  3  SHALL carry the index of the requester that supplied out_msg.
REQ-010 out_rdy  input  1  SHALL be the downstream accept; a transfer occurs when out_val and out_rdy are both high.

Function
REQ-011 Block SHALL arbitrate 8 requesters onto one registered output stage with valid/ready handshakes on both sides.
REQ-012 Load enable ld SHALL be (!out_val | out_rdy), so full throughput is one message per cycle.
REQ-013 Priority pointer ptr (3 bits) SHALL define search order ptr, ptr+1, ..., ptr+7 mod 8.
REQ-014 Grant g SHALL be the first requester in that order with req_val set; with no req_val set, there SHALL be no grant.
REQ-015 req_rdy[g] SHALL be 1 only when ld=1 and a grant exists; all other req_rdy bits SHALL be 0.
REQ-016 req_rdy SHALL depend combinationally only on req_val, ptr and out_val/out_rdy, never on req_msg.
REQ-017 On ld with a grant, the next edge SHALL load out_msg <= req_msg slot g, out_src <= g, out_val <= 1, and ptr <= (g+1) mod 8 (7 wraps to 0).
REQ-018 On ld without a grant, the next edge SHALL set out_val <= 0, leaving out_msg, out_src and ptr unchanged.
REQ-019 When out_val=1 and out_rdy=0, out_msg, out_src, out_val and ptr SHALL hold, and all req_rdy SHALL be 0.
REQ-020 Accept and refill in the same cycle (out_val=1, out_rdy=1, grant present) SHALL replace the output with no bubble.
REQ-021 Latency from req acceptance to out_val SHALL be exactly 1 cycle.
REQ-022 ptr SHALL advance only on an accepted upstream transfer, never on idle cycles.
REQ-023 A requester dropping req_val while not granted SHALL be permitted and SHALL NOT affect ptr.
REQ-024 With all 8 requesters continuously valid and out_rdy=1, grants SHALL cycle 0,1,...,7,0; no requester waits more than 7 grants.

Reset
REQ-025 While rst_n=0, outputs SHALL be out_val=0, out_msg=0, out_src=0, req_rdy=0, and ptr SHALL be 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard any held message without a downstream transfer.
REQ-027 On the first edge after rst_n rises, ld SHALL be 1 and arbitration SHALL start from ptr=0.

Structure
REQ-028 Package dl_arb_pkg SHALL define NUM_REQ=8 and SRC_W=3; dl_rr_arb8 SHALL import it.
REQ-029 Message selection SHALL instantiate dl_mux8 with sel=g, NUM_BITS passed through.
REQ-030 Grant search SHALL be purely combinational; the only state SHALL be ptr, out_val, out_msg and out_src.

Verification
REQ-031 Reset then req_val=8'h01, msg0=32'hA5A5_0000, out_rdy=1 -> req_rdy=8'h01; next cycle out_val=1, out_msg=32'hA5A5_0000, out_src=0, ptr=1.
REQ-032 req_val=8'hFF held, out_rdy=1 for 10 cycles -> out_src sequence 0,1,2,3,4,5,6,7,0,1; one req_rdy bit per cycle.
REQ-033 out_val=1 with out_src=3, out_rdy=0 for 4 cycles while req_val=8'h30 -> req_rdy=0 and outputs stable; when out_rdy=1, grant=4 and next out_src=4.
REQ-034 ptr=7, req_val=8'h81 -> grant 7, then ptr=0, next grant 0 (wrap).
REQ-035 rst_n pulsed low asynchronously mid-cycle while out_val=1 -> out_val=0 immediately; after release, ptr=0 and req_val=8'h04 is granted to 2.
REQ-036 req_val=0 with out_rdy=1 after a transfer -> out_val=0 next cycle and ptr unchanged.

Source files
------------

// File: rtl/dl_arb_pkg.sv
// Shared constants, grant type and round-robin search for the 8-way arbiter.
package dl_arb_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned SRC_W   = 3;

   typedef struct packed {
      logic             vld;
      logic [SRC_W-1:0] idx;
   } grant_t;

   // First set bit of req, searching from ptr upward with wrap-around.
   function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SRC_W-1:0]   ptr);
      grant_t           g;
      logic [SRC_W-1:0] cand;
      g.vld = 1'b0;
      g.idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ptr + SRC_W'(k);
         if (!g.vld && req[cand]) begin
            g.vld = 1'b1;
            g.idx = cand;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/dl_mux8.sv
// 8:1 message multiplexer over a packed bus of NUM_BITS-wide slots.
module dl_mux8
   import dl_arb_pkg::*;
#(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic [NUM_REQ*NUM_BITS-1:0] in_msg,
   input  logic [SRC_W-1:0]            sel,
   output logic [NUM_BITS-1:0]         out_msg
);

   always_comb begin
      out_msg = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (sel == SRC_W'(i)) begin
            out_msg = in_msg[i*NUM_BITS +: NUM_BITS];
         end
      end
   end

endmodule

// File: rtl/dl_rr_arb8.sv
// Round-robin arbiter of 8 valid/ready requesters into a single registered
// output stage; the priority pointer moves past each accepted requester.
module dl_rr_arb8
   import dl_arb_pkg::*;
#(
   parameter int unsigned NUM_BITS = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_val,
   input  logic [NUM_REQ*NUM_BITS-1:0] req_msg,
   output logic [NUM_REQ-1:0]          req_rdy,
   output logic                        out_val,
   output logic [NUM_BITS-1:0]         out_msg,
   output logic [SRC_W-1:0]            out_src,
   input  logic                        out_rdy
);

   logic [SRC_W-1:0]    ptr_q,     ptr_d;
   logic                out_val_q, out_val_d;
   logic [NUM_BITS-1:0] out_msg_q, out_msg_d;
   logic [SRC_W-1:0]    out_src_q, out_src_d;

   logic                ld;
   grant_t              gnt;
   logic [NUM_BITS-1:0] sel_msg;

   assign ld  = !out_val_q || out_rdy;
   assign gnt = rr_pick(req_val, ptr_q);

   dl_mux8 #(
      .NUM_BITS (NUM_BITS)
   ) u_mux (
      .in_msg  (req_msg),
      .sel     (gnt.idx),
      .out_msg (sel_msg)
   );

   // rst_n gates req_rdy so nothing is accepted while reset is held.
   always_comb begin
      req_rdy = '0;
      if (rst_n && ld && gnt.vld) begin
         req_rdy = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt.idx;
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      out_val_d = out_val_q;
      out_msg_d = out_msg_q;
      out_src_d = out_src_q;
      if (ld) begin
         if (gnt.vld) begin
            out_val_d = 1'b1;
            out_msg_d = sel_msg;
            out_src_d = gnt.idx;
            ptr_d     = gnt.idx + SRC_W'(1);
         end else begin
            out_val_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         out_val_q <= 1'b0;
         out_msg_q <= '0;
         out_src_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         out_val_q <= out_val_d;
         out_msg_q <= out_msg_d;
         out_src_q <= out_src_d;
      end
   end

   assign out_val = out_val_q;
   assign out_msg = out_msg_q;
   assign out_src = out_src_q;

endmodule
